fp_class_sched: RTL and testbench
=================================

// Module: fp_class_sched
// PURPOSE
//  Round-robin scheduler that shares one IEEE-754 single-precision classifier among N_REQ requesters.
//  Grants at most one request per cycle and classifies it combinationally.
//  Returns the one-hot class with the requester id through a one-entry registered output with valid/ready backpressure.
//  Sits between the lanes that issue FP operands and the exception/dispatch logic that consumes the class.
// PARAMETERS
//  N_REQ   4   number of requesters (>=2)
//  ID_W    2   width of resp_id, = clog2(N_REQ)
//  CNT_W   16  width of each statistics counter (FP_CLASS_STATS_EN only)
// PORTS
//  clk        in   1          clock, rising edge
//  rst_n      in   1          asynchronous active-low reset
//  req_valid  in   N_REQ      requester i presents an operand
//  req_num    in   32*N_REQ   operand of requester i in bits [32*i+31:32*i]
//  req_ready  out  N_REQ      one-hot; requester i accepted this cycle
//  resp_valid out  1          output register holds a result
//  resp_ready in   1          consumer takes the result
//  resp_id    out  ID_W       index of the requester that owns the result
//  resp_num   out  32         operand echoed back
//  resp_type  out  5          one-hot class: 00001 zero, 00010 normal, 00100 subnormal, 01000 inf, 10000 NaN
//  stat_clr   in   1          synchronous clear of the statistics counters
//  stat_cnt   out  5*CNT_W    per-class counters; slot k counts resp_type bit k
// BEHAVIOUR
//  Reset: resp_valid=0, resp_id=0, resp_num=0, resp_type=0, rr_ptr=0, stat_cnt=0; req_ready=0 while rst_n=0.
//  Output FSM, 2 states:
//   - EMPTY -> FULL on accept.
//   - FULL -> EMPTY on resp_valid&&resp_ready with no new accept.
//   - FULL -> FULL on drain+accept in the same cycle.
//  accept_en = !resp_valid || resp_ready. Full throughput is 1 result per cycle.
//  Arbitration:
//   - Search starts at rr_ptr and proceeds upward with wrap from N_REQ-1 to 0.
//   - The first i with req_valid[i] wins.
//   - req_ready[winner] = accept_en; all other bits are 0.
//  On accept, rr_ptr <= winner+1 (wrap to 0 at N_REQ). Without an accept, rr_ptr holds.
//  Latency: a request accepted in cycle t shows resp_valid=1 from cycle t+1.
//  While resp_valid && !resp_ready, resp_id, resp_num and resp_type hold stable and every req_ready is 0.
//  Classification from exponent e=num[30:23] and fraction f=num[22:0]; sign is ignored:
//   - e==0,f==0 -> zero
//   - e==0,f!=0 -> subnormal
//   - e==8'hFF,f==0 -> inf
//   - e==8'hFF,f!=0 -> NaN
//   - else -> normal
//  Requester protocol: a requester keeps req_valid and req_num stable until it sees req_ready. The scheduler never drops a request.
//  Reset mid-operation discards any held result and returns rr_ptr to 0.
// CONFIGURATION
//  Macro FP_CLASS_STATS_EN defined:
//   - Five CNT_W counters increment on each resp handshake, in the slot of the one-hot resp_type.
//   - Counters saturate at all-ones.
//   - stat_clr zeroes every counter on the next edge. If stat_clr and an increment occur together, clear wins and the result is 0.
//  Macro not defined: no counter flops are built; stat_cnt is tied to 0 and stat_clr is ignored.
// STRUCTURE
//  Shared package fp_class_pkg:
//   - FP_ZERO/NORMAL/SUBNORMAL/INF/NAN one-hot localparams
//   - EXP_MAX = 8'hFF
//   - FP_TYPE_W = 5
//  Sub-module fp_classify: purely combinational, num[31:0] -> type[4:0].
//  Scheduler (this file): round-robin arbiter, output register/FSM and the optional counters.
// TESTING
//  1. Reset, then req_valid=0001, num0=32'h0000_0000, resp_ready=1 -> req_ready=0001; next cycle resp_valid=1, id=0, type=00001.
//  2. All four valid with 3F80_0000, 0000_0001, 7F80_0000, 7FC0_0000, resp_ready=1 ->
//     grants 0,1,2,3 on consecutive cycles; types 00010, 00100, 01000, 10000.
//  3. Result held with resp_ready=0 for 3 cycles -> resp fields stable, req_ready=0;
//     on release, the next grant goes to the index after the last winner.
//  4. rst_n asserted low asynchronously while FULL -> resp_valid=0 immediately; after release, first grant starts from requester 0.
//  5. FP_CLASS_STATS_EN with CNT_W=4: 20 handshakes of FF80_0001 -> NaN count saturates at 4'hF;
//     stat_clr together with a handshake -> count=0.
//  6. Only req_valid[2] asserted with rr_ptr=3 -> wrap-around search grants 2; rr_ptr becomes 3.

Source files
------------

// File: rtl/fp_class_pkg.sv
// Shared definitions for the FP classifier scheduler: one-hot class codes,
// exponent limits and the output-register state encoding.
package fp_class_pkg;

   localparam int FP_TYPE_W = 5;

   localparam logic [FP_TYPE_W-1:0] FP_ZERO      = 5'b00001;
   localparam logic [FP_TYPE_W-1:0] FP_NORMAL    = 5'b00010;
   localparam logic [FP_TYPE_W-1:0] FP_SUBNORMAL = 5'b00100;
   localparam logic [FP_TYPE_W-1:0] FP_INF       = 5'b01000;
   localparam logic [FP_TYPE_W-1:0] FP_NAN       = 5'b10000;

   localparam logic [7:0] EXP_MAX = 8'hFF;

   typedef enum logic {
      ST_EMPTY = 1'b0,
      ST_FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/fp_classify.sv
// Combinational IEEE-754 single-precision classifier. The sign bit does not
// affect the class.
module fp_classify
   import fp_class_pkg::*;
(
   input  logic [31:0]          num_i,
   output logic [FP_TYPE_W-1:0] type_o
);

   logic [7:0]  exp_w;
   logic [22:0] frac_w;
   logic        unused_sign;

   assign exp_w       = num_i[30:23];
   assign frac_w      = num_i[22:0];
   assign unused_sign = num_i[31];

   // Decode exponent/fraction into a one-hot class.
   always_comb begin
      type_o = FP_NORMAL;
      if (exp_w == 8'h00) begin
         type_o = (frac_w == 23'd0) ? FP_ZERO : FP_SUBNORMAL;
      end else if (exp_w == EXP_MAX) begin
         type_o = (frac_w == 23'd0) ? FP_INF : FP_NAN;
      end
   end

endmodule

// File: rtl/fp_class_sched.sv
// Round-robin scheduler sharing one FP classifier among N_REQ requesters,
// with a one-entry registered output and valid/ready backpressure.
// Optional statistics counters are built when FP_CLASS_STATS_EN is defined;
// otherwise stat_cnt is tied to zero and stat_clr is ignored.
//
// state    | meaning
// ST_EMPTY | output register free, any winner is accepted
// ST_FULL  | output register holds a result for the consumer
module fp_class_sched
   import fp_class_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int ID_W  = 2,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [N_REQ-1:0]       req_valid,
   input  logic [32*N_REQ-1:0]    req_num,
   output logic [N_REQ-1:0]       req_ready,
   output logic                   resp_valid,
   input  logic                   resp_ready,
   output logic [ID_W-1:0]        resp_id,
   output logic [31:0]            resp_num,
   output logic [FP_TYPE_W-1:0]   resp_type,
   input  logic                   stat_clr,
   output logic [5*CNT_W-1:0]     stat_cnt
);

   out_state_e           state_q;
   logic [ID_W-1:0]      rr_ptr_q;
   logic [ID_W-1:0]      rr_ptr_d;
   logic [ID_W-1:0]      resp_id_q;
   logic [31:0]          resp_num_q;
   logic [FP_TYPE_W-1:0] resp_type_q;

   logic                 found;
   logic [ID_W-1:0]      winner;
   logic                 accept_en;
   logic                 accept;
   logic [31:0]          sel_num;
   logic [FP_TYPE_W-1:0] sel_type;
   logic                 handshake;

   assign resp_valid = (state_q == ST_FULL);
   assign resp_id    = resp_id_q;
   assign resp_num   = resp_num_q;
   assign resp_type  = resp_type_q;

   assign accept_en = !resp_valid || resp_ready;
   assign accept    = found && accept_en && rst_n;
   assign handshake = resp_valid && resp_ready;

   // Round-robin search starting at rr_ptr, wrapping at N_REQ.
   always_comb begin
      int idx;
      found  = 1'b0;
      winner = '0;
      idx    = 0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(rr_ptr_q) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req_valid[idx]) begin
            found  = 1'b1;
            winner = ID_W'(idx);
         end
      end
   end

   // One-hot grant; gated by rst_n so nothing is accepted during reset.
   always_comb begin
      req_ready = '0;
      if (accept) req_ready[winner] = 1'b1;
   end

   // Pointer moves past the winner only when a request is accepted.
   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (accept) begin
         rr_ptr_d = (int'(winner) == N_REQ-1) ? '0 : winner + ID_W'(1);
      end
   end

   assign sel_num = req_num[32*int'(winner) +: 32];

   fp_classify u_classify (
      .num_i  (sel_num),
      .type_o (sel_type)
   );

   // Output register FSM; a drain and a new accept in one cycle stay FULL.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_EMPTY;
         rr_ptr_q    <= '0;
         resp_id_q   <= '0;
         resp_num_q  <= '0;
         resp_type_q <= '0;
      end else begin
         rr_ptr_q <= rr_ptr_d;
         case (state_q)
            ST_EMPTY: begin
               if (accept) state_q <= ST_FULL;
            end
            ST_FULL: begin
               if (!accept && resp_ready) state_q <= ST_EMPTY;
            end
            default: state_q <= ST_EMPTY;
         endcase
         if (accept) begin
            resp_id_q   <= winner;
            resp_num_q  <= sel_num;
            resp_type_q <= sel_type;
         end
      end
   end

`ifdef FP_CLASS_STATS_EN
   logic [CNT_W-1:0] cnt_q [5];

   // Per-class saturating counters; clear has priority over increment.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 5; k++) cnt_q[k] <= '0;
      end else if (stat_clr) begin
         for (int k = 0; k < 5; k++) cnt_q[k] <= '0;
      end else if (handshake) begin
         for (int k = 0; k < 5; k++) begin
            if (resp_type_q[k] && (cnt_q[k] != {CNT_W{1'b1}})) begin
               cnt_q[k] <= cnt_q[k] + CNT_W'(1);
            end
         end
      end
   end

   for (genvar g = 0; g < 5; g++) begin : g_stat
      assign stat_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
   end
`else
   logic unused_stat;
   assign unused_stat = stat_clr ^ handshake;
   assign stat_cnt    = '0;
`endif

endmodule

// File: tb/tb_fp_class_sched.sv
// Directed bench for fp_class_sched: reset, classification, round-robin order,
// backpressure, async reset, wrap-around and the statistics counters.
module tb_fp_class_sched;

   localparam int N_REQ = 4;
   localparam int ID_W  = 2;
   localparam int CNT_W = 4;

   logic                 clk = 1'b0;
   logic                 rst_n;
   logic [N_REQ-1:0]     req_valid;
   logic [32*N_REQ-1:0]  req_num;
   logic [N_REQ-1:0]     req_ready;
   logic                 resp_valid;
   logic                 resp_ready;
   logic [ID_W-1:0]      resp_id;
   logic [31:0]          resp_num;
   logic [4:0]           resp_type;
   logic                 stat_clr;
   logic [5*CNT_W-1:0]   stat_cnt;

   int errs   = 0;
   int checks = 0;

   fp_class_sched #(.N_REQ(N_REQ), .ID_W(ID_W), .CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_num    (req_num),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_id    (resp_id),
      .resp_num   (resp_num),
      .resp_type  (resp_type),
      .stat_clr   (stat_clr),
      .stat_cnt   (stat_cnt)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n      = 1'b0;
      req_valid  = '0;
      req_num    = '0;
      resp_ready = 1'b0;
      stat_clr   = 1'b0;
      step();
      step();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n      = 1'b0;
      req_valid  = 4'b1111;
      req_num    = '0;
      resp_ready = 1'b1;
      stat_clr   = 1'b0;
      step();
      checks++;
      if (req_ready !== 4'b0000) begin errs++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
      checks++;
      if (resp_valid !== 1'b0 || resp_id !== 2'd0 || resp_num !== 32'd0 || resp_type !== 5'd0) begin
         errs++; $display("FAIL reset_resp got v=%b id=%0d num=%h type=%b want all zero", resp_valid, resp_id, resp_num, resp_type);
      end
      checks++;
      if (stat_cnt !== '0) begin errs++; $display("FAIL reset_stat got=%h want=0", stat_cnt); end
      rst_n     = 1'b1;
      req_valid = 4'b0001;
      req_num   = '0;
      #2;
      checks++;
      if (req_ready !== 4'b0001) begin errs++; $display("FAIL t1_grant got=%b want=0001", req_ready); end
      step();
      req_valid = '0;
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd0 || resp_type !== 5'b00001) begin
         errs++; $display("FAIL t1_resp got v=%b id=%0d type=%b want v=1 id=0 type=00001", resp_valid, resp_id, resp_type);
      end
      step();
      checks++;
      if (resp_valid !== 1'b0) begin errs++; $display("FAIL t1_drain got=%b want=0", resp_valid); end
   endtask

   task automatic test_classes();
      logic [31:0] nums  [4];
      logic [4:0]  types [4];
      nums  = '{32'h3F80_0000, 32'h0000_0001, 32'h7F80_0000, 32'h7FC0_0000};
      types = '{5'b00010, 5'b00100, 5'b01000, 5'b10000};
      do_reset();
      resp_ready = 1'b1;
      for (int i = 0; i < 4; i++) req_num[32*i +: 32] = nums[i];
      req_valid = 4'b1111;
      for (int i = 0; i < 4; i++) begin
         #2;
         checks++;
         if (req_ready !== (4'b0001 << i)) begin errs++; $display("FAIL t2_grant%0d got=%b want=%b", i, req_ready, 4'b0001 << i); end
         step();
         req_valid[i] = 1'b0;
         checks++;
         if (resp_valid !== 1'b1 || resp_id !== ID_W'(i) || resp_type !== types[i] || resp_num !== nums[i]) begin
            errs++; $display("FAIL t2_resp%0d got v=%b id=%0d num=%h type=%b want v=1 id=%0d num=%h type=%b",
                             i, resp_valid, resp_id, resp_num, resp_type, i, nums[i], types[i]);
         end
      end
      step();
      checks++;
      if (resp_valid !== 1'b0) begin errs++; $display("FAIL t2_drain got=%b want=0", resp_valid); end
   endtask

   task automatic test_backpressure();
      // rr_ptr is 0 after the previous test.
      for (int i = 0; i < 4; i++) req_num[32*i +: 32] = 32'h8000_0000 | (32'h0000_0010 << i);
      req_num[31:0] = 32'hFF80_0000;
      req_valid  = 4'b1111;
      resp_ready = 1'b0;
      step();
      req_valid[0] = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #2;
         checks++;
         if (req_ready !== 4'b0000 || resp_valid !== 1'b1 || resp_id !== 2'd0 ||
             resp_num !== 32'hFF80_0000 || resp_type !== 5'b01000) begin
            errs++; $display("FAIL t3_hold%0d got rdy=%b v=%b id=%0d num=%h type=%b want rdy=0000 v=1 id=0 num=ff800000 type=01000",
                             c, req_ready, resp_valid, resp_id, resp_num, resp_type);
         end
         step();
      end
      resp_ready = 1'b1;
      #2;
      checks++;
      if (req_ready !== 4'b0010) begin errs++; $display("FAIL t3_next got=%b want=0010", req_ready); end
      step();
      req_valid = '0;
      checks++;
      if (resp_id !== 2'd1 || resp_type !== 5'b00100) begin
         errs++; $display("FAIL t3_resp got id=%0d type=%b want id=1 type=00100", resp_id, resp_type);
      end
      step();
   endtask

   task automatic test_async_reset();
      // rr_ptr is 2 here.
      req_num[95:64] = 32'h4000_0000;
      req_valid      = 4'b0100;
      resp_ready     = 1'b0;
      step();
      req_valid = 4'b1111;
      checks++;
      if (resp_valid !== 1'b1 || resp_id !== 2'd2) begin errs++; $display("FAIL t4_full got v=%b id=%0d want v=1 id=2", resp_valid, resp_id); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 4'b0000) begin
         errs++; $display("FAIL t4_async got v=%b rdy=%b want v=0 rdy=0000", resp_valid, req_ready);
      end
      step();
      rst_n = 1'b1;
      #2;
      checks++;
      if (req_ready !== 4'b0001) begin errs++; $display("FAIL t4_restart got=%b want=0001", req_ready); end
      step();
      req_valid  = '0;
      resp_ready = 1'b1;
      step();
   endtask

   task automatic test_wrap();
      do_reset();
      resp_ready     = 1'b1;
      req_num[95:64] = 32'h8000_0000;
      req_valid      = 4'b0100;
      step();
      checks++;
      if (resp_id !== 2'd2 || resp_type !== 5'b00001) begin errs++; $display("FAIL t6_first got id=%0d type=%b want id=2 type=00001", resp_id, resp_type); end
      req_num[95:64] = 32'h8070_0000;
      #2;
      checks++;
      if (req_ready !== 4'b0100) begin errs++; $display("FAIL t6_wrap got=%b want=0100", req_ready); end
      step();
      checks++;
      if (resp_id !== 2'd2 || resp_type !== 5'b00100) begin errs++; $display("FAIL t6_resp got id=%0d type=%b want id=2 type=00100", resp_id, resp_type); end
      req_valid = 4'b1111;
      #2;
      checks++;
      if (req_ready !== 4'b1000) begin errs++; $display("FAIL t6_ptr got=%b want=1000", req_ready); end
      step();
      req_valid = '0;
      step();
   endtask

   task automatic test_stats();
      do_reset();
      resp_ready    = 1'b1;
      req_num[31:0] = 32'hFF80_0001;
      req_valid     = 4'b0001;
`ifdef FP_CLASS_STATS_EN
      for (int i = 0; i < 20; i++) begin
         step();
         if (i == 5) begin
            checks++;
            if (stat_cnt[4*CNT_W +: CNT_W] !== 4'd5) begin errs++; $display("FAIL t5_mid got=%h want=5", stat_cnt[4*CNT_W +: CNT_W]); end
         end
      end
      req_valid = '0;
      step();
      checks++;
      if (stat_cnt !== {4'hF, 16'h0000}) begin errs++; $display("FAIL t5_sat got=%h want=f0000", stat_cnt); end
      req_valid = 4'b0001;
      step();
      req_valid = '0;
      stat_clr  = 1'b1;
      checks++;
      if (resp_valid !== 1'b1) begin errs++; $display("FAIL t5_pending got=%b want=1", resp_valid); end
      step();
      stat_clr = 1'b0;
      checks++;
      if (stat_cnt !== '0) begin errs++; $display("FAIL t5_clr got=%h want=0", stat_cnt); end
`else
      for (int i = 0; i < 20; i++) step();
      req_valid = '0;
      stat_clr  = 1'b1;
      step();
      stat_clr = 1'b0;
      checks++;
      if (stat_cnt !== '0) begin errs++; $display("FAIL t5_tied got=%h want=0", stat_cnt); end
`endif
   endtask

   initial begin
      fork
         begin
            test_reset();
            test_classes();
            test_backpressure();
            test_async_reset();
            test_wrap();
            test_stats();
         end
         begin
            #100000;
            errs++;
            $display("FAIL timeout got=running want=done");
         end
      join_any
      disable fork;
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
